pwm_multi_channel: RTL and testbench



---
 rtl/pwm_multi_channel.sv | 94 +++++++++
 tb/tb_pwm_multi_channel.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared period counter.
// Every channel has its own duty and output polarity. A duty write is held in
// a per-channel shadow register. It moves into the active register only at a
// period boundary, or on any idle cycle, so a period never shows a mix of two
// duties.
module pwm_multi_channel #(
   parameter int NUM_CH = 4,
   parameter int DUTY_W = 8,
   parameter int PERIOD = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              wr_valid,
   input  logic [3:0]        wr_ch,
   input  logic [DUTY_W-1:0] wr_duty,
   input  logic [NUM_CH-1:0] polarity,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_tick
);

   localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
   localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);

   logic [DUTY_W-1:0] cnt;
   logic [DUTY_W-1:0] active [NUM_CH];
   logic [DUTY_W-1:0] shadow [NUM_CH];
   logic [NUM_CH-1:0] pending;
   logic              wrap;
   logic              apply;

   // Saturate a requested duty to a full period (constant active level).
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      return (d > PERIOD_V) ? PERIOD_V : d;
   endfunction

   // Shadow-to-active transfer happens at the wrap, and on every idle cycle.
   assign wrap  = (cnt == LAST_CNT);
   assign apply = !en || wrap;

   // Shared period counter and boundary pulse; idle holds the counter at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         period_tick <= 1'b0;
      end else begin
         period_tick <= en && wrap;
         if (apply) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Per-channel shadow/active duty registers. A write on a transfer cycle
   // only reaches the shadow and stays pending until the next transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            active[ch] <= '0;
            shadow[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (apply && pending[ch]) begin
               active[ch] <= shadow[ch];
            end
            if (wr_valid && (wr_ch == 4'(ch))) begin
               shadow[ch]  <= clamp_duty(wr_duty);
               pending[ch] <= 1'b1;
            end else if (apply) begin
               pending[ch] <= 1'b0;
            end
         end
      end
   end

   // Registered outputs: the compare runs one cycle behind the counter.
   // When idle, each output holds its inactive level.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_out <= '0;
      end else if (!en) begin
         pwm_out <= polarity;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_out[ch] <= polarity[ch] ^ (cnt < active[ch]);
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed testbench for pwm_multi_channel.
// A cycle-level reference predicts pwm_out and period_tick for every edge.
// Per-period high-cycle counts are checked against the written duties.
module tb_pwm_multi_channel;

   localparam int NUM_CH = 4;
   localparam int DUTY_W = 8;
   localparam int PERIOD = 100;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              wr_valid;
   logic [3:0]        wr_ch;
   logic [DUTY_W-1:0] wr_duty;
   logic [NUM_CH-1:0] polarity;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_tick;

   typedef struct packed {
      logic              tick;
      logic [NUM_CH-1:0] pwm;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   int   m_cnt = 0;
   int   m_act [NUM_CH];
   int   m_sh  [NUM_CH];
   bit   m_pend[NUM_CH];

   logic [NUM_CH-1:0] obs_pwm;
   logic              obs_tick = 1'b0;

   pwm_multi_channel #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD)) dut (
      .clk(clk), .reset(reset), .en(en), .wr_valid(wr_valid), .wr_ch(wr_ch),
      .wr_duty(wr_duty), .polarity(polarity), .pwm_out(pwm_out),
      .period_tick(period_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Predict the outputs of the coming edge from the inputs now applied.
   task automatic model_edge();
      exp_t e;
      bit   apply;
      if (reset) begin
         e = '0;
         m_cnt = 0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            m_act[ch] = 0; m_sh[ch] = 0; m_pend[ch] = 0;
         end
      end else begin
         e.tick = en && (m_cnt == PERIOD - 1);
         for (int ch = 0; ch < NUM_CH; ch++)
            e.pwm[ch] = en ? (polarity[ch] ^ (m_cnt < m_act[ch])) : polarity[ch];
         apply = !en || (m_cnt == PERIOD - 1);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (apply && m_pend[ch]) m_act[ch] = m_sh[ch];
            if (wr_valid && int'(wr_ch) == ch) begin
               m_sh[ch]   = (int'(wr_duty) > PERIOD) ? PERIOD : int'(wr_duty);
               m_pend[ch] = 1;
            end else if (apply) begin
               m_pend[ch] = 0;
            end
         end
         m_cnt = apply ? 0 : m_cnt + 1;
      end
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      obs_pwm  = pwm_out;
      obs_tick = period_tick;
      e = sb_q.pop_front();
      vectors++;
      assert ({obs_tick, obs_pwm} === e) else begin
         miscompares++;
         $error("FAIL cycle t=%0t: observed tick=%b pwm=%b, expected tick=%b pwm=%b",
                $time, obs_tick, obs_pwm, e.tick, e.pwm);
      end
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!obs_tick && n < 2 * PERIOD) begin
         step();
         n++;
      end
      check("wait_tick", int'(obs_tick), 1);
   endtask

   task automatic step_until(input int c);
      int n = 0;
      while (m_cnt != c && n < 2 * PERIOD) begin
         step();
         n++;
      end
      if (m_cnt != c) begin
         miscompares++;
         $error("FAIL step_until: counter at %0d, wanted %0d", m_cnt, c);
      end
   endtask

   // Count active-high cycles of one channel over a full period that starts
   // now, with an optional write issued at counter value wr_at.
   task automatic count_steps(input string tag, input int ch, input int exp_hi,
                              input int wr_at = -1, input int wch = 0, input int wd = 0);
      int hi    = 0;
      int ticks = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (m_cnt == wr_at) begin
            wr_valid = 1'b1; wr_ch = 4'(wch); wr_duty = DUTY_W'(wd);
         end
         step();
         wr_valid = 1'b0;
         hi    += int'(obs_pwm[ch]);
         ticks += int'(obs_tick);
      end
      check(tag, hi, exp_hi);
      check({tag, "_ticks"}, ticks, 1);
   endtask

   task automatic count_period(input string tag, input int ch, input int exp_hi,
                               input int wr_at = -1, input int wch = 0, input int wd = 0);
      wait_tick();
      count_steps(tag, ch, exp_hi, wr_at, wch, wd);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_duty = '0;
      polarity = '0;
      step();
      step();
      check("reset_pwm", int'(obs_pwm), 0);
      check("reset_tick", int'(obs_tick), 0);
      reset = 1'b0;

      // 1: preload ch0 while idle, then run
      wr_valid = 1'b1; wr_ch = 4'd0; wr_duty = 8'd50;
      step();
      wr_valid = 1'b0;
      step();
      en = 1'b1;
      count_steps("t1_first", 0, 50);
      count_period("t1_second", 0, 50);

      // 2: duty change mid-period applies at the next boundary
      count_period("t2_set", 1, 0, 20, 1, 10);
      count_period("t2_keep", 1, 10, 40, 1, 90);
      count_period("t2_new", 1, 90);

      // 3: write on the wrap cycle is deferred one period
      count_period("t3_old", 2, 0, 99, 2, 30);
      count_period("t3_still", 2, 0);
      count_period("t3_new", 2, 30);

      // 4: duty 0, full period, clamped, then inverted polarity
      count_period("t4_zero", 3, 0, 10, 3, 100);
      count_period("t4_full", 3, 100, 10, 3, 200);
      count_period("t4_clamp", 3, 100);
      polarity = 4'b1000;
      count_period("t4_inv_full", 3, 0, 10, 3, 0);
      count_period("t4_inv_zero", 3, 100);

      // 5: out-of-range channel ignored; last of two writes wins
      count_period("t5_badch", 0, 50, 20, 7, 60);
      count_period("t5_badch_after", 0, 50);
      step_until(30);
      wr_valid = 1'b1; wr_ch = 4'd0; wr_duty = 8'd20;
      step();
      wr_valid = 1'b0;
      step_until(60);
      wr_valid = 1'b1; wr_ch = 4'd0; wr_duty = 8'd70;
      step();
      wr_valid = 1'b0;
      count_period("t5_last", 0, 70);

      // 6: reset mid-period with a colliding write, then clean restart
      count_period("t6_pre", 0, 70, 5, 0, 80);
      count_period("t6_run80", 0, 80);
      step_until(57);
      reset = 1'b1;
      wr_valid = 1'b1; wr_ch = 4'd1; wr_duty = 8'd44;
      step();
      reset = 1'b0; wr_valid = 1'b0;
      check("t6_reset_pwm", int'(obs_pwm), 0);
      check("t6_reset_tick", int'(obs_tick), 0);
      count_steps("t6_zero_ch0", 0, 0);
      count_period("t6_zero_ch1", 1, 0);
      en = 1'b0;
      wr_valid = 1'b1; wr_ch = 4'd0; wr_duty = 8'd25;
      step();
      wr_valid = 1'b0;
      step();
      en = 1'b1;
      count_steps("t6_rerun", 0, 25);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
